// File: rtl/dt_param_gen.sv
// dt_param_gen: turns one double dt into delta_t, dt^2/2 and dt^3/2 using one
// shared external multiplier; results are double-buffered behind a publish step.
module dt_param_gen #(
    parameter int DBL_WIDTH   = 64,
    parameter int MUL_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DBL_WIDTH-1:0] dt_in,
    output logic [DBL_WIDTH-1:0] delta_t,
    output logic [DBL_WIDTH-1:0] half_dt2,
    output logic [DBL_WIDTH-1:0] half_dt3,
    output logic                 params_valid,
    output logic                 busy,
    output logic                 done,
    output logic                 err_timeout,
    output logic                 mul_go,
    output logic [DBL_WIDTH-1:0] mul_a,
    output logic [DBL_WIDTH-1:0] mul_b,
    input  logic                 finish,
    input  logic [DBL_WIDTH-1:0] mul_result
);

    localparam int TW = $clog2(MUL_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(MUL_TIMEOUT - 1);
    localparam logic [DBL_WIDTH-1:0] FP_HALF =
        DBL_WIDTH'(64'h3FE0_0000_0000_0000);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SQ,
        S_HALF,
        S_CUBE,
        S_PUB
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DBL_WIDTH-1:0] dt_r;
    logic [DBL_WIDTH-1:0] h2;
    logic [DBL_WIDTH-1:0] h3;
    logic [TW-1:0]        tmo_cnt;

    logic is_zero;
    logic accept;
    logic zero_go;
    logic issue_sq;
    logic ld_sq;
    logic ld_h2;
    logic ld_h3;
    logic publish;
    logic waiting;
    logic tmo_hit;

    // Sign bit ignored so both +0.0 and -0.0 take the short path.
    assign is_zero = ~|dt_in[DBL_WIDTH-2:0];
    assign busy    = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = is_zero ? S_PUB : S_SQ;
                end
            end
            S_SQ: begin
                if (finish) begin
                    state_nxt = S_HALF;
                end else if (tmo_hit) begin
                    state_nxt = S_IDLE;
                end
            end
            S_HALF: begin
                if (finish) begin
                    state_nxt = S_CUBE;
                end else if (tmo_hit) begin
                    state_nxt = S_IDLE;
                end
            end
            S_CUBE: begin
                if (finish) begin
                    state_nxt = S_PUB;
                end else if (tmo_hit) begin
                    state_nxt = S_IDLE;
                end
            end
            S_PUB: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        accept   = 1'b0;
        zero_go  = 1'b0;
        issue_sq = 1'b0;
        ld_sq    = 1'b0;
        ld_h2    = 1'b0;
        ld_h3    = 1'b0;
        publish  = 1'b0;
        waiting  = 1'b0;
        unique case (state)
            S_IDLE: begin
                accept   = start;
                zero_go  = start & is_zero;
                issue_sq = start & ~is_zero;
            end
            S_SQ: begin
                waiting = 1'b1;
                ld_sq   = finish;
            end
            S_HALF: begin
                waiting = 1'b1;
                ld_h2   = finish;
            end
            S_CUBE: begin
                waiting = 1'b1;
                ld_h3   = finish;
            end
            S_PUB: begin
                publish = 1'b1;
            end
            default: begin
                accept = 1'b0;
            end
        endcase
        tmo_hit = waiting & ~finish & (tmo_cnt == TMO_LAST);
    end

    // The square is never stored separately: it goes straight to mul_a.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_go <= 1'b0;
            mul_a  <= '0;
            mul_b  <= '0;
        end else begin
            mul_go <= issue_sq | ld_sq | ld_h2;
            if (issue_sq) begin
                mul_a <= dt_in;
                mul_b <= dt_in;
            end else if (ld_sq) begin
                mul_a <= mul_result;
                mul_b <= FP_HALF;
            end else if (ld_h2) begin
                mul_a <= mul_result;
                mul_b <= dt_r;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (issue_sq | ld_sq | ld_h2) begin
            tmo_cnt <= '0;
        end else if (waiting) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dt_r <= '0;
            h2   <= '0;
            h3   <= '0;
        end else begin
            if (accept) begin
                dt_r <= dt_in;
            end
            if (zero_go) begin
                h2 <= '0;
                h3 <= '0;
            end
            if (ld_h2) begin
                h2 <= mul_result;
            end
            if (ld_h3) begin
                h3 <= mul_result;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_timeout <= 1'b0;
        end else if (accept) begin
            err_timeout <= 1'b0;
        end else if (tmo_hit) begin
            err_timeout <= 1'b1;
        end
    end

    // Published triple only changes here, so consumers never see a mix.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            delta_t      <= '0;
            half_dt2     <= '0;
            half_dt3     <= '0;
            params_valid <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= publish;
            if (publish) begin
                delta_t      <= dt_r;
                half_dt2     <= h2;
                half_dt3     <= h3;
                params_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dt_param_gen.sv
// Directed bench for dt_param_gen with a behavioural fixed-latency multiplier
// that can be made to hang or to emit a stray finish.
module tb_dt_param_gen;

    localparam int LAT = 4;
    localparam logic [63:0] D_2   = 64'h4000_0000_0000_0000;
    localparam logic [63:0] D_4   = 64'h4010_0000_0000_0000;
    localparam logic [63:0] D_H   = 64'h3FE0_0000_0000_0000;
    localparam logic [63:0] D_8TH = 64'h3FC0_0000_0000_0000;
    localparam logic [63:0] D_16TH = 64'h3FB0_0000_0000_0000;
    localparam logic [63:0] D_3   = 64'h4008_0000_0000_0000;
    localparam logic [63:0] D_NZ  = 64'h8000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] dt_in;
    logic [63:0] delta_t;
    logic [63:0] half_dt2;
    logic [63:0] half_dt3;
    logic        params_valid;
    logic        busy;
    logic        done;
    logic        err_timeout;
    logic        mul_go;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic        finish;
    logic [63:0] mul_result;

    int n_checks = 0;
    int n_pass   = 0;
    int go_cnt   = 0;

    logic        hang = 1'b0;
    logic        inj  = 1'b0;
    logic        pend = 1'b0;
    int          rem  = 0;
    logic [63:0] held = '0;

    dt_param_gen #(
        .DBL_WIDTH  (64),
        .MUL_TIMEOUT(8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dt_in       (dt_in),
        .delta_t     (delta_t),
        .half_dt2    (half_dt2),
        .half_dt3    (half_dt3),
        .params_valid(params_valid),
        .busy        (busy),
        .done        (done),
        .err_timeout (err_timeout),
        .mul_go      (mul_go),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .finish      (finish),
        .mul_result  (mul_result)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] fmul(input logic [63:0] a, input logic [63:0] b);
        return $realtobits($bitstoreal(a) * $bitstoreal(b));
    endfunction

    initial begin
        finish     = 1'b0;
        mul_result = '0;
    end

    always @(posedge clk) begin
        finish <= 1'b0;
        if (mul_go) go_cnt <= go_cnt + 1;
        if (mul_go && !hang) begin
            pend <= 1'b1;
            rem  <= LAT - 1;
            held <= fmul(mul_a, mul_b);
        end else if (pend && !hang) begin
            if (rem == 1) begin
                finish     <= 1'b1;
                mul_result <= held;
                pend       <= 1'b0;
            end else begin
                rem <= rem - 1;
            end
        end
        if (inj) finish <= 1'b1;
    end

    task automatic do_start(input logic [63:0] d);
        dt_in = d;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        n_checks++;
        if ({delta_t, half_dt2, half_dt3} !== '0)
            $display("FAIL reset_data: got %h %h %h want 0", delta_t, half_dt2, half_dt3);
        else n_pass++;
        n_checks++;
        if ({params_valid, busy, done, err_timeout, mul_go} !== 5'b0)
            $display("FAIL reset_flags: got %b want 00000",
                     {params_valid, busy, done, err_timeout, mul_go});
        else n_pass++;
    endtask

    task automatic test_two;
        int lat;
        do_start(D_2);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL busy_rise: got %b want 1", busy);
        else n_pass++;
        wait_done(lat);
        n_checks++;
        if (lat != 4 * LAT) $display("FAIL done_latency: got %0d want %0d", lat, 4 * LAT);
        else n_pass++;
        n_checks++;
        if ({delta_t, half_dt2, half_dt3} !== {D_2, D_2, D_4})
            $display("FAIL two_triple: got %h %h %h want %h %h %h",
                     delta_t, half_dt2, half_dt3, D_2, D_2, D_4);
        else n_pass++;
        n_checks++;
        if ({params_valid, busy} !== 2'b10)
            $display("FAIL two_flags: got pv=%b busy=%b want 1 0", params_valid, busy);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0) $display("FAIL done_pulse: got %b want 0", done);
        else n_pass++;
    endtask

    task automatic test_half;
        int   lat;
        logic bad;
        bad = 1'b0;
        lat = 0;
        do_start(D_H);
        while (!done && lat < 100) begin
            if ({delta_t, half_dt2, half_dt3} !== {D_2, D_2, D_4}) bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        n_checks++;
        if (bad) $display("FAIL hold_old: got changed want %h %h %h", D_2, D_2, D_4);
        else n_pass++;
        n_checks++;
        if ({delta_t, half_dt2, half_dt3} !== {D_H, D_8TH, D_16TH})
            $display("FAIL half_triple: got %h %h %h want %h %h %h",
                     delta_t, half_dt2, half_dt3, D_H, D_8TH, D_16TH);
        else n_pass++;
    endtask

    task automatic test_ignore_start;
        int dones;
        dones = 0;
        do_start(D_2);
        do_start(D_3);
        for (int i = 0; i < 40; i++) begin
            if (done) dones++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (dones != 1) $display("FAIL ignore_dones: got %0d want 1", dones);
        else n_pass++;
        n_checks++;
        if ({delta_t, half_dt2, half_dt3} !== {D_2, D_2, D_4})
            $display("FAIL ignore_triple: got %h %h %h want %h %h %h",
                     delta_t, half_dt2, half_dt3, D_2, D_2, D_4);
        else n_pass++;
    endtask

    task automatic test_zero;
        int base;
        int lat;
        base = go_cnt;
        do_start(D_NZ);
        wait_done(lat);
        n_checks++;
        if (lat != 1) $display("FAIL zero_latency: got %0d want 1", lat);
        else n_pass++;
        n_checks++;
        if ({delta_t, half_dt2, half_dt3} !== {D_NZ, 64'h0, 64'h0})
            $display("FAIL zero_triple: got %h %h %h want %h 0 0",
                     delta_t, half_dt2, half_dt3, D_NZ);
        else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (go_cnt != base) $display("FAIL zero_mulgo: got %0d want %0d", go_cnt - base, 0);
        else n_pass++;
    endtask

    task automatic test_timeout;
        int   lat;
        logic saw_done;
        saw_done = 1'b0;
        lat = 0;
        hang = 1'b1;
        do_start(D_2);
        while (busy && lat < 50) begin
            if (done) saw_done = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        n_checks++;
        if ({err_timeout, busy, saw_done} !== 3'b100)
            $display("FAIL tmo_flags: got err=%b busy=%b done=%b want 1 0 0",
                     err_timeout, busy, saw_done);
        else n_pass++;
        n_checks++;
        if ({delta_t, half_dt2, half_dt3, params_valid} !== {D_NZ, 64'h0, 64'h0, 1'b1})
            $display("FAIL tmo_hold: got %h %h %h pv=%b want %h 0 0 1",
                     delta_t, half_dt2, half_dt3, params_valid, D_NZ);
        else n_pass++;
        hang = 1'b0;
        do_start(D_H);
        n_checks++;
        if (err_timeout !== 1'b0) $display("FAIL tmo_clear: got %b want 0", err_timeout);
        else n_pass++;
        wait_done(lat);
        n_checks++;
        if ({delta_t, half_dt2, half_dt3} !== {D_H, D_8TH, D_16TH})
            $display("FAIL tmo_recover: got %h %h %h want %h %h %h",
                     delta_t, half_dt2, half_dt3, D_H, D_8TH, D_16TH);
        else n_pass++;
    endtask

    task automatic test_rst_mid;
        int   base;
        int   n;
        logic moved;
        base  = go_cnt;
        n     = 0;
        moved = 1'b0;
        do_start(D_2);
        while (go_cnt < base + 2 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({delta_t, half_dt2, half_dt3} !== '0 ||
            {params_valid, busy, done, err_timeout, mul_go} !== 5'b0)
            $display("FAIL rst_mid: got %h %h %h flags=%b want all 0", delta_t, half_dt2,
                     half_dt3, {params_valid, busy, done, err_timeout, mul_go});
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            inj = (i == 6);
            if (busy || done || params_valid || delta_t !== '0) moved = 1'b1;
            @(posedge clk); #1;
        end
        inj = 1'b0;
        n_checks++;
        if (moved) $display("FAIL late_finish: got state change want none");
        else n_pass++;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        dt_in = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        rst = 1'b0;
        @(posedge clk); #1;
        test_two;
        test_half;
        test_ignore_start;
        test_zero;
        test_timeout;
        test_rst_mid;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
